// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: owner-state encoding and default widths.
package dmem_arbiter_pkg;

    localparam int DATA_W_DEF     = 19;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU      = 2'd1,
        DBG_LOCK = 2'd2
    } owner_t;

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, debug and memory-side signals of the arbiter grouped as one bundle.
interface dmem_arbiter_if #(
    parameter int DATA_W = dmem_arbiter_pkg::DATA_W_DEF
);
    logic              cpu_req;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              dbg_req;
    logic              dbg_we;
    logic              dbg_lock;
    logic [DATA_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_rvalid;

    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Requesters and the memory model sit on the master side.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_stall, dbg_gnt, dbg_rdata, dbg_rvalid,
        input  mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_stall, dbg_gnt, dbg_rdata, dbg_rvalid,
        output mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating count of consecutive cycles the debug port was denied while requesting.
module starve_counter #(
    parameter int MAX = 4,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic          sat,
    output logic [CW-1:0] cnt
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CW'(MAX))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign sat = (cnt == CW'(MAX));
endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU and a debug/loader port,
// with starvation escape for debug and a lockable debug burst mode.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    dmem_arbiter_if.slave                    bus,
    output owner_t                           owner,
    output logic [$clog2(STARVE_MAX+1)-1:0]  starve_cnt
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    owner_t            owner_q, owner_d;
    logic              cpu_g, dbg_g;
    logic              sat, denied;
    logic [DATA_W-1:0] dbg_rdata_q;
    logic              dbg_rvalid_q;

    // Grant priority: active lock, lone requester, then CPU unless debug is starved.
    always_comb begin
        cpu_g = 1'b0;
        dbg_g = 1'b0;
        if (owner_q == DBG_LOCK && bus.dbg_req) begin
            dbg_g = 1'b1;
        end else if (bus.cpu_req && !bus.dbg_req) begin
            cpu_g = 1'b1;
        end else if (!bus.cpu_req && bus.dbg_req) begin
            dbg_g = 1'b1;
        end else if (bus.cpu_req && bus.dbg_req) begin
            if (sat) dbg_g = 1'b1;
            else     cpu_g = 1'b1;
        end
    end

    always_comb begin
        owner_d = IDLE;
        if (dbg_g && bus.dbg_lock) owner_d = DBG_LOCK;
        else if (cpu_g)            owner_d = CPU;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) owner_q <= IDLE;
        else      owner_q <= owner_d;
    end

    // A lock raised during a CPU grant only matters once debug actually wins.
    assign denied = bus.dbg_req && !dbg_g;

    starve_counter #(.MAX(STARVE_MAX), .CW(CW)) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (denied),
        .clr (!denied),
        .sat (sat),
        .cnt (starve_cnt)
    );

    // Flat AND-OR mux: at most one grant is ever high.
    assign bus.mem_we    = rst & ((cpu_g & bus.cpu_we) | (dbg_g & bus.dbg_we));
    assign bus.mem_addr  = ({DATA_W{cpu_g}} & bus.cpu_addr)  | ({DATA_W{dbg_g}} & bus.dbg_addr);
    assign bus.mem_wdata = ({DATA_W{cpu_g}} & bus.cpu_wdata) | ({DATA_W{dbg_g}} & bus.dbg_wdata);
    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.cpu_stall = bus.cpu_req & ~cpu_g;
    assign bus.dbg_gnt   = dbg_g;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbg_rdata_q  <= '0;
            dbg_rvalid_q <= 1'b0;
        end else begin
            dbg_rvalid_q <= dbg_g & ~bus.dbg_we;
            if (dbg_g && !bus.dbg_we) dbg_rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.dbg_rdata  = dbg_rdata_q;
    assign bus.dbg_rvalid = dbg_rvalid_q;
    assign owner          = owner_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a rule-level model.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int W  = 19;
  localparam int SM = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_W(W)) bus ();
  owner_t     owner;
  logic [2:0] starve_cnt;

  dmem_arbiter #(.DATA_W(W), .STARVE_MAX(SM)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .owner      (owner),
    .starve_cnt (starve_cnt)
  );

  // Memory environment: combinational read, synchronous write.
  logic [W-1:0] mem [16] = '{default: '0};
  assign bus.mem_rdata = mem[bus.mem_addr[3:0]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[3:0]] <= bus.mem_wdata;

  // Reference model state.
  logic [W-1:0] ref_mem [16] = '{default: '0};
  int           m_starve;
  bit           m_locked;
  bit           m_rvalid;
  logic [W-1:0] m_rdata;
  logic [W-1:0] exp_q [$];

  bit           e_dbg, e_cpu, e_stall, e_we;
  logic [W-1:0] e_addr, e_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic model_reset();
    m_starve = 0;
    m_locked = 0;
    m_rvalid = 0;
    m_rdata  = '0;
    exp_q.delete();
  endtask

  task automatic predict();
    e_dbg   = bus.dbg_req && (m_locked || !bus.cpu_req || m_starve == SM);
    e_cpu   = bus.cpu_req && !e_dbg;
    e_stall = bus.cpu_req && !e_cpu;
    e_we    = rst && ((e_cpu && bus.cpu_we) || (e_dbg && bus.dbg_we));
    e_addr  = e_cpu ? bus.cpu_addr  : (e_dbg ? bus.dbg_addr  : '0);
    e_wdata = e_cpu ? bus.cpu_wdata : (e_dbg ? bus.dbg_wdata : '0);
  endtask

  // Clock one cycle and apply the arbitration rules to the model.
  task automatic advance();
    predict();
    @(posedge clk);
    m_rvalid = e_dbg && !bus.dbg_we;
    if (m_rvalid) m_rdata = ref_mem[e_addr[3:0]];
    if (e_we) ref_mem[e_addr[3:0]] = e_wdata;
    m_locked = e_dbg && bus.dbg_lock;
    if (bus.dbg_req && !e_dbg) m_starve = (m_starve < SM) ? m_starve + 1 : SM;
    else                       m_starve = 0;
    #1;
  endtask

  task automatic drive(input bit c_req, input bit c_we, input int c_addr, input logic [W-1:0] c_wd,
                       input bit d_req, input bit d_we, input bit d_lock, input int d_addr,
                       input logic [W-1:0] d_wd);
    bus.cpu_req   = c_req;
    bus.cpu_we    = c_we;
    bus.cpu_addr  = W'(c_addr);
    bus.cpu_wdata = c_wd;
    bus.dbg_req   = d_req;
    bus.dbg_we    = d_we;
    bus.dbg_lock  = d_lock;
    bus.dbg_addr  = W'(d_addr);
    bus.dbg_wdata = d_wd;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1, 1, 3, 19'h00abc, 0, 0, 0, 0, '0);
    #2;
    n_tests++; if (owner !== IDLE) begin n_fail++; $display("FAIL reset_owner got=%0d exp=0", owner); end
    n_tests++; if (starve_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_starve got=%0d exp=0", starve_cnt); end
    n_tests++; if (bus.dbg_rvalid !== 1'b0 || bus.dbg_rdata !== '0) begin
      n_fail++; $display("FAIL reset_dbg_out got rvalid=%b rdata=%h exp 0/0", bus.dbg_rvalid, bus.dbg_rdata); end
    n_tests++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got=%b exp=0", bus.mem_we); end
    n_tests++; if (bus.cpu_stall !== 1'b0 || bus.mem_addr !== W'(3)) begin
      n_fail++; $display("FAIL reset_comb got stall=%b addr=%h exp 0/3", bus.cpu_stall, bus.mem_addr); end
    repeat (2) @(posedge clk);
    #1;
    drive(0, 0, 0, '0, 0, 0, 0, 0, '0);
    rst = 1'b1;
    model_reset();
    advance();
  endtask

  task automatic test_cpu_only();
    drive(1, 1, 5, 19'h01234, 0, 0, 0, 0, '0);
    #1;
    n_tests++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== W'(5) || bus.mem_wdata !== 19'h01234) begin
      n_fail++; $display("FAIL cpu_write got we=%b addr=%h wd=%h exp 1/5/1234", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    n_tests++; if (bus.cpu_stall !== 1'b0 || bus.dbg_gnt !== 1'b0) begin
      n_fail++; $display("FAIL cpu_grant got stall=%b gnt=%b exp 0/0", bus.cpu_stall, bus.dbg_gnt); end
    advance();
    drive(1, 0, 5, '0, 0, 0, 0, 0, '0);
    #1;
    n_tests++; if (bus.cpu_rdata !== 19'h01234 || bus.mem_we !== 1'b0) begin
      n_fail++; $display("FAIL cpu_load got rdata=%h we=%b exp 01234/0", bus.cpu_rdata, bus.mem_we); end
    advance();
  endtask

  task automatic test_dbg_read();
    drive(1, 1, 9, 19'h7ffff, 0, 0, 0, 0, '0);
    advance();
    drive(0, 0, 0, '0, 1, 0, 0, 9, '0);
    #1;
    n_tests++; if (bus.dbg_gnt !== 1'b1 || bus.cpu_stall !== 1'b0) begin
      n_fail++; $display("FAIL dbg_read_gnt got gnt=%b stall=%b exp 1/0", bus.dbg_gnt, bus.cpu_stall); end
    advance();
    drive(0, 0, 0, '0, 0, 0, 0, 0, '0);
    n_tests++; if (bus.dbg_rvalid !== 1'b1 || bus.dbg_rdata !== 19'h7ffff) begin
      n_fail++; $display("FAIL dbg_read_data got rvalid=%b rdata=%h exp 1/7ffff", bus.dbg_rvalid, bus.dbg_rdata); end
    advance();
    n_tests++; if (bus.dbg_rvalid !== 1'b0 || bus.dbg_rdata !== 19'h7ffff) begin
      n_fail++; $display("FAIL dbg_read_hold got rvalid=%b rdata=%h exp 0/7ffff", bus.dbg_rvalid, bus.dbg_rdata); end
  endtask

  task automatic test_starvation();
    for (int c = 0; c < 9; c++) begin
      drive(1, 0, $urandom_range(0, 15), '0, 1, 0, 0, $urandom_range(0, 15), '0);
      #1;
      predict();
      n_tests++; if (bus.dbg_gnt !== (c == 4) || bus.cpu_stall !== (c == 4) || bus.dbg_gnt !== e_dbg) begin
        n_fail++; $display("FAIL starve_c%0d got gnt=%b stall=%b exp gnt=%b", c, bus.dbg_gnt, bus.cpu_stall, (c == 4)); end
      n_tests++; if (int'(starve_cnt) !== m_starve) begin
        n_fail++; $display("FAIL starve_cnt_c%0d got=%0d exp=%0d", c, starve_cnt, m_starve); end
      advance();
      n_tests++; if (bus.dbg_rvalid !== m_rvalid || bus.dbg_rdata !== m_rdata) begin
        n_fail++; $display("FAIL starve_rd_c%0d got %b/%h exp %b/%h", c, bus.dbg_rvalid, bus.dbg_rdata, m_rvalid, m_rdata); end
    end
    drive(0, 0, 0, '0, 0, 0, 0, 0, '0);
    advance();
  endtask

  task automatic test_lock_burst();
    drive(0, 0, 0, '0, 1, 1, 1, 2, 19'h00111);
    #1;
    n_tests++; if (bus.dbg_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_first got=%b exp=1", bus.dbg_gnt); end
    advance();
    for (int c = 0; c < 10; c++) begin
      drive(1, 1, 7, 19'h00777, 1, 1, 1, c, W'(c) + 19'h00200);
      #1;
      n_tests++; if (bus.dbg_gnt !== 1'b1 || bus.cpu_stall !== 1'b1 || owner !== DBG_LOCK) begin
        n_fail++; $display("FAIL lock_c%0d got gnt=%b stall=%b owner=%0d exp 1/1/2", c, bus.dbg_gnt, bus.cpu_stall, owner); end
      advance();
    end
    drive(1, 1, 7, 19'h00777, 1, 1, 0, 12, 19'h00333);
    #1;
    n_tests++; if (bus.dbg_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_drop got=%b exp=1", bus.dbg_gnt); end
    advance();
    #1;
    n_tests++; if (bus.dbg_gnt !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.mem_addr !== W'(7)) begin
      n_fail++; $display("FAIL lock_release got gnt=%b stall=%b addr=%h exp 0/0/7", bus.dbg_gnt, bus.cpu_stall, bus.mem_addr); end
    advance();
    drive(0, 0, 0, '0, 0, 0, 0, 0, '0);
    advance();
  endtask

  task automatic test_reset_mid_read();
    drive(0, 0, 0, '0, 1, 0, 0, 9, '0);
    #1;
    n_tests++; if (bus.dbg_gnt !== 1'b1) begin n_fail++; $display("FAIL midrd_gnt got=%b exp=1", bus.dbg_gnt); end
    rst = 1'b0;
    #1;
    n_tests++; if (bus.dbg_rvalid !== 1'b0 || bus.dbg_rdata !== '0 || owner !== IDLE) begin
      n_fail++; $display("FAIL midrd_reset got rvalid=%b rdata=%h owner=%0d exp 0/0/0", bus.dbg_rvalid, bus.dbg_rdata, owner); end
    @(posedge clk);
    #1;
    drive(0, 0, 0, '0, 0, 0, 0, 0, '0);
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      advance();
      n_tests++; if (bus.dbg_rvalid !== 1'b0 || bus.dbg_rdata !== '0) begin
        n_fail++; $display("FAIL midrd_after_c%0d got rvalid=%b rdata=%h exp 0/0", c, bus.dbg_rvalid, bus.dbg_rdata); end
    end
  endtask

  task automatic test_idle();
    drive(0, 0, 0, '0, 0, 0, 0, 0, '0);
    for (int c = 0; c < 4; c++) begin
      #1;
      n_tests++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== '0 || bus.cpu_stall !== 1'b0 || starve_cnt !== 3'd0) begin
        n_fail++; $display("FAIL idle_c%0d got we=%b addr=%h stall=%b cnt=%0d exp 0/0/0/0", c, bus.mem_we, bus.mem_addr, bus.cpu_stall, starve_cnt); end
      advance();
    end
  endtask

  task automatic test_random();
    exp_q.delete();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15), W'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 5) == 0,
            $urandom_range(0, 15), W'($urandom));
      #1;
      predict();
      n_tests++; if (bus.dbg_gnt !== e_dbg || bus.cpu_stall !== e_stall) begin
        n_fail++; $display("FAIL rand_grant i=%0d got gnt=%b stall=%b exp %b/%b", i, bus.dbg_gnt, bus.cpu_stall, e_dbg, e_stall); end
      n_tests++; if (bus.mem_we !== e_we || bus.mem_addr !== e_addr || bus.mem_wdata !== e_wdata) begin
        n_fail++; $display("FAIL rand_mem i=%0d got %b/%h/%h exp %b/%h/%h", i, bus.mem_we, bus.mem_addr, bus.mem_wdata, e_we, e_addr, e_wdata); end
      n_tests++; if (bus.cpu_rdata !== ref_mem[e_addr[3:0]]) begin
        n_fail++; $display("FAIL rand_cpu_rdata i=%0d got=%h exp=%h", i, bus.cpu_rdata, ref_mem[e_addr[3:0]]); end
      n_tests++; if (int'(starve_cnt) !== m_starve || (owner == DBG_LOCK) !== m_locked) begin
        n_fail++; $display("FAIL rand_state i=%0d got cnt=%0d owner=%0d exp cnt=%0d lock=%b", i, starve_cnt, owner, m_starve, m_locked); end
      if (e_dbg && !bus.dbg_we) exp_q.push_back(ref_mem[bus.dbg_addr[3:0]]);
      advance();
      n_tests++; if (bus.dbg_rvalid !== m_rvalid) begin
        n_fail++; $display("FAIL rand_rvalid i=%0d got=%b exp=%b", i, bus.dbg_rvalid, m_rvalid); end
      if (bus.dbg_rvalid === 1'b1 && exp_q.size() > 0) begin
        logic [W-1:0] exp_d;
        exp_d = exp_q.pop_front();
        n_tests++; if (bus.dbg_rdata !== exp_d) begin
          n_fail++; $display("FAIL rand_rdata i=%0d got=%h exp=%h", i, bus.dbg_rdata, exp_d); end
      end else begin
        n_tests++; if (bus.dbg_rdata !== m_rdata) begin
          n_fail++; $display("FAIL rand_rdata_hold i=%0d got=%h exp=%h", i, bus.dbg_rdata, m_rdata); end
      end
    end
    n_tests++; if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL rand_leftover got=%0d exp=0", exp_q.size()); end
    drive(0, 0, 0, '0, 0, 0, 0, 0, '0);
    advance();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_cpu_only();
    test_dbg_read();
    test_idle();
    test_starvation();
    test_lock_burst();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
